read_ptr_empty_ble: RTL and testbench

- Read-side pointer and empty-flag generator for the BLE PHY asynchronous FIFO, clocked in the read domain.
- Consumes the Gray-coded write pointer after the 2-FF write-to-read synchronizer.
- Produces:
  - binary read address to the FIFO RAM,
  - Gray read pointer for the read-to-write synchronizer,
  - empty / almost-empty flags, fill level, read-data-valid strobe and a sticky underflow flag.

---
 rtl/read_ptr_empty_ble_if.sv | 25 ++
 rtl/read_ptr_empty_ble.sv | 71 +++++++
 tb/tb_read_ptr_empty_ble.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/read_ptr_empty_ble_if.sv
// rtl/read_ptr_empty_ble_if.sv - read-side FIFO pointer bundle between consumer and pointer logic
interface read_ptr_empty_ble_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  R_inc;
   logic [ADDR_WIDTH:0]   Rq2_wptr;
   logic                  R_underflow_clr;
   logic [ADDR_WIDTH-1:0] R_addr;
   logic [ADDR_WIDTH:0]   R_ptr;
   logic                  R_empty;
   logic                  R_almost_empty;
   logic [ADDR_WIDTH:0]   R_level;
   logic                  R_valid;
   logic                  R_underflow;

   modport master (
      output R_inc, Rq2_wptr, R_underflow_clr,
      input  R_addr, R_ptr, R_empty, R_almost_empty, R_level, R_valid, R_underflow
   );

   modport slave (
      input  R_inc, Rq2_wptr, R_underflow_clr,
      output R_addr, R_ptr, R_empty, R_almost_empty, R_level, R_valid, R_underflow
   );
endinterface

// File: rtl/read_ptr_empty_ble.sv
// rtl/read_ptr_empty_ble.sv - async FIFO read pointer, empty/almost-empty, level and underflow
module read_ptr_empty_ble #(
   parameter int ADDR_WIDTH = 4,
   parameter int AE_THRESH  = 2
) (
   input  logic                 R_CLK,
   input  logic                 R_rst,
   read_ptr_empty_ble_if.slave  bus
);
   localparam logic [ADDR_WIDTH:0] AE_T = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] rgray;
   logic [ADDR_WIDTH:0] rbin_next;
   logic [ADDR_WIDTH:0] rgray_next;
   logic [ADDR_WIDTH:0] wbin;
   logic [ADDR_WIDTH:0] level_next;
   logic [ADDR_WIDTH:0] level;
   logic                empty;
   logic                almost_empty;
   logic                valid;
   logic                underflow;
   logic                rd_ok;

   assign rd_ok      = bus.R_inc & ~empty;
   assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, rd_ok};
   assign rgray_next = rbin_next ^ (rbin_next >> 1);

   // Gray-to-binary: each bit is the XOR of itself and every higher Gray bit.
   always_comb begin
      wbin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         wbin[i] = ^(bus.Rq2_wptr >> i);
      end
   end

   assign level_next = wbin - rbin_next;

   always_ff @(posedge R_CLK or posedge R_rst) begin
      if (R_rst) begin
         rbin         <= '0;
         rgray        <= '0;
         level        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         valid        <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         rbin         <= rbin_next;
         rgray        <= rgray_next;
         level        <= level_next;
         // Full-width compare keeps a full FIFO (MSB differs) from looking empty.
         empty        <= (rgray_next == bus.Rq2_wptr);
         almost_empty <= (level_next <= AE_T);
         valid        <= rd_ok;
         if (bus.R_inc & empty) begin
            underflow <= 1'b1;
         end else if (bus.R_underflow_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   assign bus.R_addr         = rbin[ADDR_WIDTH-1:0];
   assign bus.R_ptr          = rgray;
   assign bus.R_empty        = empty;
   assign bus.R_almost_empty = almost_empty;
   assign bus.R_level        = level;
   assign bus.R_valid        = valid;
   assign bus.R_underflow    = underflow;
endmodule

// File: tb/tb_read_ptr_empty_ble.sv
// tb/tb_read_ptr_empty_ble.sv - randomized and directed check of read_ptr_empty_ble against a counter model
module tb_read_ptr_empty_ble;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;
   int   w_int;

   int   m_r;
   int   m_level;
   bit   m_empty;
   bit   m_ae;
   bit   m_valid;
   bit   m_uf;

   read_ptr_empty_ble_if #(.ADDR_WIDTH(4)) bus ();

   read_ptr_empty_ble #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
      .R_CLK (clk),
      .R_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] gray(input int v);
      logic [4:0] b;
      b = v[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_w(input int w);
      w_int = w;
      bus.Rq2_wptr = gray(w);
   endtask

   // Reference: count-based FIFO occupancy, evaluated at each clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_r = 0; m_level = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
      end else begin
         bit acc;
         acc = bus.R_inc && !m_empty;
         if (bus.R_inc && m_empty) m_uf = 1;
         else if (bus.R_underflow_clr) m_uf = 0;
         m_r     = (m_r + (acc ? 1 : 0)) % 32;
         m_valid = acc;
         m_level = (w_int - m_r) & 31;
         m_empty = (m_level == 0);
         m_ae    = (m_level <= 2);
      end
   end

   logic [4:0] prev_ptr;
   bit         prev_ok;
   always @(negedge clk) begin
      chk("addr",   int'(bus.R_addr), m_r % 16);
      chk("ptr",    int'(bus.R_ptr), int'(gray(m_r)));
      chk("empty",  int'(bus.R_empty), int'(m_empty));
      chk("aempty", int'(bus.R_almost_empty), int'(m_ae));
      chk("level",  int'(bus.R_level), m_level);
      chk("valid",  int'(bus.R_valid), int'(m_valid));
      chk("uflow",  int'(bus.R_underflow), int'(m_uf));
      chk("empty_eq_level0", int'(bus.R_empty), int'(bus.R_level == 0));
      if (rst) begin
         prev_ok = 0;
      end else begin
         if (prev_ok) chk("ptr_onebit", int'($countones(bus.R_ptr ^ prev_ptr) <= 1), 1);
         prev_ok  = 1;
         prev_ptr = bus.R_ptr;
      end
   end

   initial begin
      n_checks = 0; n_fails = 0; prev_ok = 0; prev_ptr = '0;
      bus.R_inc = 0; bus.R_underflow_clr = 0; drive_w(0);
      rst = 1;
      #1;
      chk("rst_empty", int'(bus.R_empty), 1);
      chk("rst_ae",    int'(bus.R_almost_empty), 1);
      chk("rst_level", int'(bus.R_level), 0);
      chk("rst_ptr",   int'(bus.R_ptr), 0);
      chk("rst_valid", int'(bus.R_valid), 0);
      tick(); tick();
      rst = 0;
      tick();

      // Three entries, three reads.
      drive_w(3);
      tick();
      chk("w3_level", int'(bus.R_level), 3);
      chk("w3_empty", int'(bus.R_empty), 0);
      chk("w3_ae",    int'(bus.R_almost_empty), 0);
      bus.R_inc = 1;
      for (int i = 0; i < 3; i++) begin
         chk("rd_addr", int'(bus.R_addr), i);
         tick();
         chk("rd_valid", int'(bus.R_valid), 1);
         chk("rd_level", int'(bus.R_level), 2 - i);
      end
      bus.R_inc = 0;
      chk("rd3_empty", int'(bus.R_empty), 1);
      chk("rd3_ptr",   int'(bus.R_ptr), 5'b00010);
      tick();
      chk("rd3_valid_drop", int'(bus.R_valid), 0);

      // Full FIFO from rbin=0.
      rst = 1; tick(); rst = 0; drive_w(16); tick();
      tick();
      chk("full_level", int'(bus.R_level), 16);
      chk("full_empty", int'(bus.R_empty), 0);
      bus.R_inc = 1;
      for (int i = 0; i < 16; i++) tick();
      bus.R_inc = 0;
      chk("full_ptr",   int'(bus.R_ptr), 5'b11000);
      chk("full_empty_after", int'(bus.R_empty), 1);
      chk("full_addr_wrap", int'(bus.R_addr), 0);

      // Advance rbin to 30, then wrap past 31 to 2.
      drive_w(30); tick();
      bus.R_inc = 1;
      for (int i = 0; i < 14; i++) tick();
      bus.R_inc = 0;
      chk("pre_wrap_ptr", int'(bus.R_ptr), int'(gray(30)));
      drive_w(34); tick();
      chk("wrap_level", int'(bus.R_level), 4);
      bus.R_inc = 1;
      for (int i = 0; i < 4; i++) tick();
      bus.R_inc = 0;
      chk("wrap_empty", int'(bus.R_empty), 1);
      chk("wrap_ptr",   int'(bus.R_ptr), 5'b00011);

      // Underflow set, hold, clear, set-beats-clear.
      bus.R_inc = 1; tick(); bus.R_inc = 0;
      chk("uf_set",   int'(bus.R_underflow), 1);
      chk("uf_valid", int'(bus.R_valid), 0);
      chk("uf_addr",  int'(bus.R_addr), 2);
      tick();
      chk("uf_hold",  int'(bus.R_underflow), 1);
      bus.R_underflow_clr = 1; tick(); bus.R_underflow_clr = 0;
      chk("uf_clr",   int'(bus.R_underflow), 0);
      bus.R_inc = 1; bus.R_underflow_clr = 1; tick();
      bus.R_inc = 0; bus.R_underflow_clr = 0;
      chk("uf_set_wins", int'(bus.R_underflow), 1);

      // Same-cycle read and write at level 1.
      drive_w(w_int + 1); tick();
      bus.R_inc = 1; drive_w(w_int + 1); tick(); bus.R_inc = 0;
      chk("rw_level", int'(bus.R_level), 1);
      chk("rw_empty", int'(bus.R_empty), 0);

      // Async reset mid-burst at level 5.
      drive_w(w_int + 4); tick();
      chk("pre_rst_level", int'(bus.R_level), 5);
      bus.R_inc = 1;
      #2 rst = 1;
      #1;
      chk("arst_level", int'(bus.R_level), 0);
      chk("arst_empty", int'(bus.R_empty), 1);
      chk("arst_ptr",   int'(bus.R_ptr), 0);
      chk("arst_addr",  int'(bus.R_addr), 0);
      chk("arst_valid", int'(bus.R_valid), 0);
      chk("arst_uf",    int'(bus.R_underflow), 0);
      tick();
      bus.R_inc = 0; drive_w(0);
      tick();
      rst = 0;
      drive_w(2); tick();
      bus.R_inc = 1;
      chk("post_rst_addr", int'(bus.R_addr), 0);
      tick(); bus.R_inc = 0;
      chk("post_rst_valid", int'(bus.R_valid), 1);

      // Randomized traffic; writer never lets occupancy exceed the depth.
      for (int c = 0; c < 4000; c++) begin
         int room;
         bus.R_inc = ($urandom % 4) != 0;
         bus.R_underflow_clr = ($urandom % 8) == 0;
         room = 16 - ((w_int - m_r) & 31);
         if (($urandom % 3) == 0 && room > 0)
            drive_w(w_int + int'($urandom_range(0, room)));
         tick();
      end
      bus.R_inc = 0;
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
